// File: rtl/sample_voice_pkg.sv
// Shared types and constants for the sample playback voice.
package sample_voice_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StPlay
    } voice_state_e;

    localparam int unsigned DAC_SHIFT = 6;
    localparam logic [15:0] ONE_STEP  = 16'h0100;

endpackage

// File: rtl/sample_voice_phase.sv
// Phase accumulator for sample_voice: advances by the step on each tick and
// flags a loop wrap or the end of a one-shot sample.
module sample_voice_phase #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned FRAC_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              tick_i,
    input  logic [15:0]       stp_i,
    input  logic [ADDR_W-1:0] len_i,
    input  logic              lp_i,
    output logic [ADDR_W-1:0] off_o,
    output logic              wrap_o,
    output logic              end_o
);
    localparam int unsigned PhW = ADDR_W + FRAC_W;

    logic [PhW-1:0] phase_q, phase_d;
    logic [PhW:0]   nxt;
    logic [PhW-1:0] wrapped;
    logic           past_end;

    always_comb begin
        // One spare bit so a step past the top of the address space still compares as past end.
        nxt      = {1'b0, phase_q} + (PhW + 1)'(stp_i);
        wrapped  = nxt[PhW-1:0] - {len_i, {FRAC_W{1'b0}}};
        past_end = nxt[PhW:FRAC_W] >= {1'b0, len_i};
        wrap_o   = tick_i && past_end && lp_i;
        end_o    = tick_i && past_end && !lp_i;
        off_o    = phase_q[PhW-1:FRAC_W];

        phase_d = phase_q;
        if (clear_i) begin
            phase_d = '0;
        end else if (wrap_o) begin
            phase_d = wrapped;
        end else if (tick_i && !past_end) begin
            phase_d = nxt[PhW-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/sample_voice.sv
// Single-channel PCM voice: fetches 8-bit samples over a req/ack ROM port and
// steps through them at a programmable 8.8 pitch, feeding one mixer channel.
module sample_voice
    import sample_voice_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned FRAC_W    = 8,
    parameter int unsigned DAC_SHIFT = sample_voice_pkg::DAC_SHIFT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic [15:0]       step,
    input  logic              loop,
    input  logic              sample_tick,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_req,
    input  logic              rom_ack,
    input  logic [7:0]        rom_data,
    output logic [15:0]       dac_out,
    output logic              sample_playing
);
    voice_state_e      state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [15:0]       stp_q, stp_d;
    logic              lp_q, lp_d;
    logic [ADDR_W-1:0] fetched_off_q, fetched_off_d;
    logic [ADDR_W-1:0] req_off_q, req_off_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              rom_req_q, rom_req_d;
    logic [15:0]       dac_q, dac_d;
    logic              playing_q, playing_d;

    logic              start_go;
    logic              go_idle;
    logic              phase_tick;
    logic              end_flag;
    logic              wrap_unused;
    logic [ADDR_W-1:0] off;

    assign start_go   = start && (length != '0);
    assign phase_tick = sample_tick && (state_q != StIdle);

    sample_voice_phase #(
        .ADDR_W(ADDR_W),
        .FRAC_W(FRAC_W)
    ) u_phase (
        .clk_i  (clk),
        .rst_i  (reset),
        .clear_i(start_go),
        .tick_i (phase_tick),
        .stp_i  (stp_q),
        .len_i  (len_q),
        .lp_i   (lp_q),
        .off_o  (off),
        .wrap_o (wrap_unused),
        .end_o  (end_flag)
    );

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        len_d         = len_q;
        stp_d         = stp_q;
        lp_d          = lp_q;
        fetched_off_d = fetched_off_q;
        req_off_d     = req_off_q;
        rom_addr_d    = rom_addr_q;
        rom_req_d     = rom_req_q;
        dac_d         = dac_q;
        playing_d     = playing_q;
        go_idle       = 1'b0;

        if (start_go) begin
            // Restart from any state; an outstanding fetch is simply abandoned.
            state_d       = StFetch;
            base_d        = start_addr;
            len_d         = length;
            stp_d         = step;
            lp_d          = loop;
            fetched_off_d = '1;
            req_off_d     = '0;
            rom_addr_d    = start_addr;
            rom_req_d     = 1'b1;
            playing_d     = 1'b1;
        end else if (start || stop) begin
            go_idle = 1'b1;
        end else begin
            case (state_q)
                StFetch: begin
                    if (end_flag) begin
                        go_idle = 1'b1;
                    end else if (rom_ack) begin
                        state_d       = StPlay;
                        dac_d         = 16'(rom_data) << DAC_SHIFT;
                        fetched_off_d = req_off_q;
                        rom_req_d     = 1'b0;
                    end
                end
                StPlay: begin
                    if (end_flag) begin
                        go_idle = 1'b1;
                    end else if (off != fetched_off_q) begin
                        state_d    = StFetch;
                        req_off_d  = off;
                        rom_addr_d = base_q + off;
                        rom_req_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (go_idle) begin
            state_d   = StIdle;
            rom_req_d = 1'b0;
            dac_d     = '0;
            playing_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            base_q        <= '0;
            len_q         <= '0;
            stp_q         <= '0;
            lp_q          <= 1'b0;
            fetched_off_q <= '1;
            req_off_q     <= '0;
            rom_addr_q    <= '0;
            rom_req_q     <= 1'b0;
            dac_q         <= '0;
            playing_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            len_q         <= len_d;
            stp_q         <= stp_d;
            lp_q          <= lp_d;
            fetched_off_q <= fetched_off_d;
            req_off_q     <= req_off_d;
            rom_addr_q    <= rom_addr_d;
            rom_req_q     <= rom_req_d;
            dac_q         <= dac_d;
            playing_q     <= playing_d;
        end
    end

    assign rom_addr       = rom_addr_q;
    assign rom_req        = rom_req_q;
    assign dac_out        = dac_q;
    assign sample_playing = playing_q;

endmodule

// File: tb/tb_sample_voice.sv
// Bench for sample_voice: directed scenarios plus random start/stop/tick traffic,
// checked against a tick-level playback model and a delayed-ack ROM responder.
module tb_sample_voice;
    import sample_voice_pkg::*;

    localparam int unsigned FRAC = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, stop, loop, sample_tick;
    logic [15:0] start_addr, length, step;
    logic [15:0] rom_addr;
    logic        rom_req, rom_ack;
    logic [7:0]  rom_data;
    logic [15:0] dac_out;
    logic        sample_playing;

    int          n_tests = 0;
    int          n_fail  = 0;

    // Playback model: phase kept as a plain integer in 8.8 units.
    bit          m_play;
    int unsigned m_phase, m_base, m_len, m_stp;
    bit          m_lp;
    bit          ev_start, ev_stop, ev_end;

    // ROM responder control: fixed delay, or random when negative; manual hands ack to the bench.
    int          ack_delay;
    bit          rom_manual;
    bit          busy;
    int          wcnt;

    logic [15:0] addr_q[$];
    logic [15:0] dac_q[$];

    logic [15:0] t1_addr [4] = '{16'h1000, 16'h1001, 16'h1002, 16'h1003};
    logic [15:0] t1_dac  [4] = '{16'h0000, 16'h2000, 16'h3FC0, 16'h1000};
    int unsigned t2_off  [6] = '{1, 0, 1, 0, 1, 0};

    bit          r_st, r_sp, r_tk;
    int          bad;

    always #5 clk = ~clk;

    sample_voice #(
        .ADDR_W   (16),
        .FRAC_W   (8),
        .DAC_SHIFT(6)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .start_addr    (start_addr),
        .length        (length),
        .step          (step),
        .loop          (loop),
        .sample_tick   (sample_tick),
        .rom_addr      (rom_addr),
        .rom_req       (rom_req),
        .rom_ack       (rom_ack),
        .rom_data      (rom_data),
        .dac_out       (dac_out),
        .sample_playing(sample_playing)
    );

    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        case (a)
            16'h1000: return 8'h00;
            16'h1001: return 8'h80;
            16'h1002: return 8'hFF;
            16'h1003: return 8'h40;
            default:  return 8'(32'(a[7:0] ^ a[15:8]) * 7 + 3);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (!rom_manual) begin
            rom_ack = 1'b0;
            if (!rom_req) begin
                busy = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    wcnt = (ack_delay < 0) ? int'($urandom_range(0, 4)) : ack_delay;
                end
                if (wcnt == 0) begin
                    rom_ack  = 1'b1;
                    rom_data = rom_byte(rom_addr);
                    busy     = 1'b0;
                end else begin
                    wcnt--;
                end
            end
        end
    end

    task automatic model_update(input bit st, input bit sp, input bit tk);
        int unsigned nxt;
        ev_start = 0;
        ev_stop  = 0;
        ev_end   = 0;
        if (st && length != 16'd0) begin
            m_base   = 32'(start_addr);
            m_len    = 32'(length);
            m_stp    = 32'(step);
            m_lp     = loop;
            m_phase  = 0;
            m_play   = 1;
            ev_start = 1;
        end else if (st || sp) begin
            m_play  = 0;
            ev_stop = 1;
        end else if (m_play && tk) begin
            nxt = m_phase + m_stp;
            if ((nxt >> FRAC) >= m_len) begin
                if (m_lp) begin
                    m_phase = nxt - (m_len << FRAC);
                end else begin
                    m_play = 0;
                    ev_end = 1;
                end
            end else begin
                m_phase = nxt;
            end
        end
    endtask

    // Called at a falling edge: drive inputs, advance the model, cross one rising edge, check.
    task automatic clk_cycle(input bit st, input bit sp, input bit tk);
        int unsigned off_before;
        bit          was_play, was_req, was_ack;
        logic [7:0]  ack_byte;
        off_before  = m_phase >> FRAC;
        was_play    = m_play;
        was_req     = rom_req;
        was_ack     = rom_ack && rom_req;
        ack_byte    = rom_data;
        start       = st;
        stop        = sp;
        sample_tick = tk;
        model_update(st, sp, tk);
        @(negedge clk);
        start       = 1'b0;
        stop        = 1'b0;
        sample_tick = 1'b0;
        check("playing", 32'(sample_playing), 32'(m_play));
        if (!m_play) begin
            check("idle_dac", 32'(dac_out), 32'd0);
            check("idle_req", 32'(rom_req), 32'd0);
        end else if (ev_start) begin
            check("start_req", 32'(rom_req), 32'd1);
            check("start_addr", 32'(rom_addr), m_base);
            addr_q.push_back(rom_addr);
        end else if (rom_req && !was_req) begin
            check("fetch_addr", 32'(rom_addr), 32'(16'(m_base + off_before)));
            addr_q.push_back(rom_addr);
        end else if (was_ack) begin
            check("ack_dac", 32'(dac_out), 32'(ack_byte) << 6);
            check("ack_req", 32'(rom_req), 32'd0);
            dac_q.push_back(dac_out);
        end else if (!rom_req && !was_req && was_play) begin
            check("hold_dac", 32'(dac_out),
                  32'({rom_byte(16'(m_base + off_before)), 6'b0}));
        end
    endtask

    task automatic go(input logic [15:0] a, input logic [15:0] n, input logic [15:0] s,
                      input logic l);
        start_addr = a;
        length     = n;
        step       = s;
        loop       = l;
        clk_cycle(1, 0, 0);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        loop        = 1'b0;
        sample_tick = 1'b0;
        start_addr  = '0;
        length      = '0;
        step        = '0;
        rom_ack     = 1'b0;
        rom_data    = '0;
        rom_manual  = 1'b0;
        ack_delay   = 0;
        busy        = 1'b0;
        m_play      = 0;
        m_phase     = 0;
        repeat (2) @(negedge clk);
        check("rst_dac", 32'(dac_out), 32'd0);
        check("rst_play", 32'(sample_playing), 32'd0);
        check("rst_req", 32'(rom_req), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic one-shot playback.
        ack_delay = 2;
        addr_q.delete();
        dac_q.delete();
        go(16'h1000, 16'd4, ONE_STEP, 1'b0);
        for (int i = 1; i <= 40; i++) clk_cycle(0, 0, (i % 8) == 0);
        check("t1_nreq", 32'(addr_q.size()), 32'd4);
        check("t1_ndac", 32'(dac_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t1_addr", (i < addr_q.size()) ? 32'(addr_q[i]) : 32'hDEAD, 32'(t1_addr[i]));
            check("t1_dac", (i < dac_q.size()) ? 32'(dac_q[i]) : 32'hDEAD, 32'(t1_dac[i]));
        end
        check("t1_end_play", 32'(sample_playing), 32'd0);
        check("t1_end_dac", 32'(dac_out), 32'd0);

        // Looping with a fractional step.
        ack_delay = 1;
        bad       = 0;
        go(16'h2000, 16'd3, 16'h0180, 1'b1);
        repeat (6) clk_cycle(0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            clk_cycle(0, 0, 1);
            for (int j = 0; j < 11; j++) begin
                clk_cycle(0, 0, 0);
                if (!sample_playing) bad++;
            end
            check("t2_dac", 32'(dac_out), 32'({rom_byte(16'h2000 + 16'(t2_off[k])), 6'b0}));
        end
        check("t2_gap", 32'(bad), 32'd0);
        clk_cycle(0, 1, 0);

        // Ticks keep arriving during a slow fetch.
        ack_delay = 20;
        bad       = 0;
        addr_q.delete();
        go(16'h3000, 16'd40, ONE_STEP, 1'b0);
        for (int i = 1; i <= 30; i++) begin
            clk_cycle(0, 0, (i % 4) == 0);
            if (i <= 20 && (!rom_req || rom_addr != 16'h3000)) bad++;
        end
        check("t3_stable", 32'(bad), 32'd0);
        check("t3_next", (addr_q.size() > 1) ? 32'(addr_q[1]) : 32'hDEAD, 32'h3005);
        clk_cycle(0, 1, 0);

        // Stop during a fetch, then a late ack.
        rom_manual = 1'b1;
        rom_ack    = 1'b0;
        go(16'h4000, 16'd8, ONE_STEP, 1'b1);
        repeat (3) clk_cycle(0, 0, 0);
        check("t4_req_before", 32'(rom_req), 32'd1);
        clk_cycle(0, 1, 0);
        check("t4_req", 32'(rom_req), 32'd0);
        check("t4_play", 32'(sample_playing), 32'd0);
        rom_ack  = 1'b1;
        rom_data = 8'hAA;
        clk_cycle(0, 0, 0);
        rom_ack = 1'b0;
        clk_cycle(0, 0, 0);
        check("t4_late_ack", 32'(dac_out), 32'd0);
        rom_manual = 1'b0;

        // Restart priority, then start with zero length.
        ack_delay = 1;
        go(16'h4000, 16'd20, ONE_STEP, 1'b0);
        for (int i = 1; i <= 48; i++) clk_cycle(0, 0, (i % 6) == 0 && i <= 42);
        check("t5_off7", 32'(dac_out), 32'({rom_byte(16'h4007), 6'b0}));
        start_addr = 16'h5000;
        length     = 16'd5;
        step       = ONE_STEP;
        loop       = 1'b0;
        clk_cycle(1, 1, 0);
        check("t5_restart_addr", 32'(rom_addr), 32'h5000);
        check("t5_restart_req", 32'(rom_req), 32'd1);
        repeat (5) clk_cycle(0, 0, 0);
        go(16'h6000, 16'd0, ONE_STEP, 1'b0);
        check("t5_len0_play", 32'(sample_playing), 32'd0);
        check("t5_len0_req", 32'(rom_req), 32'd0);

        // Asynchronous reset between edges.
        go(16'h6000, 16'd10, 16'h0080, 1'b1);
        for (int i = 1; i <= 20; i++) clk_cycle(0, 0, (i % 3) == 0);
        check("t6_pre_play", 32'(sample_playing), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t6_dac", 32'(dac_out), 32'd0);
        check("t6_play", 32'(sample_playing), 32'd0);
        check("t6_req", 32'(rom_req), 32'd0);
        check("t6_addr", 32'(rom_addr), 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        m_play = 0;
        m_phase = 0;

        // Random traffic with random ack latency.
        ack_delay = -1;
        for (int i = 0; i < 4000; i++) begin
            r_st = 0;
            r_sp = 0;
            r_tk = ($urandom_range(0, 3) == 0);
            if (m_play ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 15) == 0)) begin
                r_st       = 1;
                start_addr = 16'($urandom);
                length     = ($urandom_range(0, 19) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
                loop       = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 9) == 0) begin
                    step = 16'd0;
                end else if (loop && length != 16'd0) begin
                    step = 16'($urandom_range(1, 32'(length) * 256 - 1));
                end else begin
                    step = 16'($urandom_range(1, 16'h0300));
                end
                if ($urandom_range(0, 5) == 0) r_sp = 1;
            end else if ($urandom_range(0, 399) == 0) begin
                r_sp = 1;
            end
            clk_cycle(r_st, r_sp, r_tk);
        end
        clk_cycle(0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
